// File: rtl/alu_md_if.sv
// alu_md_if: request/result handshake bundle for the alu_md unit.
// Handshake: a transfer happens on a rising edge where the producer's valid
// and the consumer's ready are both high; valid must not depend on ready.
// Request channel is iValid/oReady (+ iOP/iA/iB); result channel is
// oValid/iReady (+ oC).
interface alu_md_if #(
  parameter int WIDTH = 32
) ();
  logic             iValid;
  logic             oReady;
  logic [3:0]       iOP;
  logic [WIDTH-1:0] iA;
  logic [WIDTH-1:0] iB;
  logic             oValid;
  logic             iReady;
  logic [WIDTH-1:0] oC;

  modport master (
    output iValid, iOP, iA, iB, iReady,
    input  oReady, oValid, oC
  );

  modport slave (
    input  iValid, iOP, iA, iB, iReady,
    output oReady, oValid, oC
  );
endinterface

// File: rtl/alu_md.sv
// alu_md: single-issue integer ALU. Simple ops finish directly; MUL/MULHU and
// non-trivial divides run a WIDTH-cycle shift-add / restoring iteration.
// The bus interface instance must be built with the same WIDTH as this module.
module alu_md #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic       iClk,
  input  logic       nRst,
  alu_md_if.slave    bus,
  output logic [1:0] oState
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_op;     // low opcode bits; bit 2 selects divide vs multiply
  logic [WIDTH-1:0] r_a;      // multiplicand
  logic [WIDTH-1:0] r_b;      // divisor magnitude
  logic [WIDTH-1:0] r_hi;     // product high half / partial remainder
  logic [WIDTH-1:0] r_lo;     // multiplier bits / dividend bits -> quotient
  logic [WIDTH-1:0] r_c;
  logic             r_neg;    // negate the divide result at the end
  logic [SHW-1:0]   r_cnt;

  logic [SHW-1:0]   w_sh;
  logic             w_sgn;
  logic             w_is_rem;
  logic             w_is_mul;
  logic             w_is_div;
  logic             w_bzero;
  logic             w_ovf;
  logic             w_iter;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;
  logic [WIDTH-1:0] w_mag;
  logic [WIDTH-1:0] w_fin;

  assign w_accept = bus.iValid && (r_state == S_IDLE);
  assign w_last   = (r_cnt == SHW'(WIDTH - 1));

  // Decode the live request and compute every single-cycle result,
  // including the divide-by-zero and signed-overflow shortcuts.
  always_comb begin
    w_sh     = bus.iB[SHW-1:0];
    w_sgn    = ~bus.iOP[0];
    w_is_rem = bus.iOP[1];
    w_is_mul = (bus.iOP[3:1] == 3'b101);
    w_is_div = (bus.iOP[3:2] == 2'b11);
    w_bzero  = (bus.iB == '0);
    w_ovf    = w_sgn && (bus.iA == MOST_NEG) && (bus.iB == '1);
    w_iter   = w_is_mul || (w_is_div && !w_bzero && !w_ovf);
    w_a_mag  = (w_sgn && bus.iA[WIDTH-1]) ? -bus.iA : bus.iA;
    w_b_mag  = (w_sgn && bus.iB[WIDTH-1]) ? -bus.iB : bus.iB;
    w_res    = '0;
    case (bus.iOP)
      4'h0: w_res = bus.iA + bus.iB;
      4'h1: w_res = bus.iA - bus.iB;
      4'h2: w_res = bus.iA ^ bus.iB;
      4'h3: w_res = bus.iA | bus.iB;
      4'h4: w_res = bus.iA & bus.iB;
      4'h5: w_res = bus.iA << w_sh;
      4'h6: w_res = bus.iA >> w_sh;
      4'h7: w_res = $signed(bus.iA) >>> w_sh;
      4'h8: w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.iA) < $signed(bus.iB))};
      4'h9: w_res = {{(WIDTH-1){1'b0}}, (bus.iA < bus.iB)};
      default: begin
        // Only the divide shortcuts reach DONE directly from this branch.
        if (w_bzero) w_res = w_is_rem ? bus.iA : '1;
        else         w_res = w_is_rem ? '0 : bus.iA;
      end
    endcase
  end

  // One multiply (shift-add) or divide (restoring) step, plus the final
  // result selection and sign fix-up used on the last CALC cycle.
  always_comb begin
    w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
    w_trial  = {r_hi, r_lo[WIDTH-1]} - {1'b0, r_b};
    w_hi_nxt = '0;
    w_lo_nxt = '0;
    if (r_op[2]) begin
      if (!w_trial[WIDTH]) begin
        w_hi_nxt = w_trial[WIDTH-1:0];
        w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_hi_nxt = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
        w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      {w_hi_nxt, w_lo_nxt} = {w_sum, r_lo[WIDTH-1:1]};
    end
    w_mag = r_op[1] ? w_hi_nxt : w_lo_nxt;
    if (r_op[2]) w_fin = r_neg ? -w_mag : w_mag;
    else         w_fin = r_op[0] ? w_hi_nxt : w_lo_nxt;
  end

  // State register.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.iValid) w_state_nxt = w_iter ? S_CALC : S_DONE;
      S_CALC:  if (w_last)     w_state_nxt = S_DONE;
      S_DONE:  if (bus.iReady) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state; the result register is held through DONE.
  always_comb begin
    bus.oReady = (r_state == S_IDLE);
    bus.oValid = (r_state == S_DONE);
    bus.oC     = r_c;
    oState     = r_state;
  end

  // Datapath: latch operands on accept, iterate in CALC, capture the result.
  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      r_op  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_c   <= '0;
      r_neg <= 1'b0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_op  <= bus.iOP[2:0];
      r_a   <= bus.iA;
      r_b   <= w_is_div ? w_b_mag : bus.iB;
      r_hi  <= '0;
      r_lo  <= w_is_div ? w_a_mag : bus.iB;
      r_neg <= w_is_rem ? (w_sgn & bus.iA[WIDTH-1])
                        : (w_sgn & (bus.iA[WIDTH-1] ^ bus.iB[WIDTH-1]));
      r_cnt <= '0;
      if (!w_iter) r_c <= w_res;
    end else if (r_state == S_CALC) begin
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) r_c <= w_fin;
    end
  end

endmodule

// File: doc/alu_md.md
ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 Parameter WIDTH, default 32, sets the operand and result width in bits; legal values are 8, 16, 32 and 64.
REQ-002 Parameter SHW, default $clog2(WIDTH), sets the shift-amount width; SHW is derived from WIDTH and is not overridden.
REQ-003 iClk  input  1  the single clock; all state updates on its rising edge.
REQ-004 nRst  input  1  reset; asynchronous, active-low.
REQ-005 iValid  input  1  request valid.
REQ-006 oReady  output  1  unit can accept a request.
REQ-007 iOP  input  4  operation code, per REQ-012.
REQ-008 iA, iB  input  WIDTH  operands.
REQ-009 oValid  output  1  result valid.
REQ-010 iReady  input  1  consumer accepts the result.
REQ-011 oC  output  WIDTH  result.

Function
REQ-012 iOP decode: 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 SLTU, A MUL (low WIDTH bits), B MULHU (high WIDTH bits, unsigned), C DIV, D DIVU, E REM, F REMU.
REQ-013 A request is accepted on a rising edge where iValid and oReady are both high; iOP, iA and iB are latched at that edge, and later input changes have no effect.
REQ-014 The state machine has three states: IDLE, CALC and DONE; oReady is high only in IDLE, and oValid is high only in DONE.
REQ-015 Transitions from IDLE on accept:
- ops 0-9 -> DONE;
- DIV/DIVU/REM/REMU with iB == 0 -> DONE;
- DIV/REM with iA == most-negative and iB == all-ones -> DONE;
- all other ops A-F -> CALC.
REQ-016 CALC performs one iteration per cycle for exactly WIDTH cycles, then moves to DONE.
REQ-016a Resulting latency: oValid rises after edge N+1 for DONE-direct ops and after edge N+WIDTH+1 for iterative ops, where N is the accept edge.
REQ-017 Multiply uses an unsigned shift-add algorithm on WIDTH-bit operands producing a 2*WIDTH product; MUL returns the low half and MULHU returns the high half.
REQ-018 Divide uses an unsigned restoring algorithm on operand magnitudes.
- DIV: the quotient is negated when the operand signs differ.
- REM: the remainder takes the sign of iA.
- Quotient rounds toward zero.
REQ-019 Divide by zero: DIV/DIVU return all-ones; REM/REMU return iA.
REQ-020 Signed overflow (most-negative / -1): DIV returns iA; REM returns 0.
REQ-021 Shifts use only iB[SHW-1:0]; SRA replicates iA[WIDTH-1].
REQ-022 SLT compares iA and iB as two's-complement values; SLTU compares them unsigned; both return 1 or 0, zero-extended to WIDTH.
REQ-023 ADD, SUB and MUL wrap modulo 2^WIDTH; no carry or overflow flag is produced.
REQ-024 In DONE, oC is held stable until a rising edge with iReady high, which returns the state to IDLE.
REQ-025 No new request is accepted on the DONE->IDLE edge; minimum throughput is one request per two cycles.
REQ-026 iOP is 4 bits and all 16 codes are defined; there is no illegal-opcode case.

Reset
REQ-027 While nRst is low, regardless of clock:
- state = IDLE, oReady = 1, oValid = 0, oC = 0;
- multiply/divide accumulators, counter and latched operands = 0.
REQ-028 Reset asserted during CALC or DONE abandons the operation; no result is produced after reset releases.
REQ-029 The first accept is possible on the first rising edge after nRst deasserts.

Verification (WIDTH=32 unless noted)
REQ-030 ADD with A=0xFFFFFFFF, B=1 -> oC=0x00000000; oValid high 1 cycle after accept; oReady low for that cycle.
REQ-031 SRA with A=0x80000000, B=0x24 -> 0xF8000000 (shift by 4). SLT with A=0xFFFFFFFF, B=1 -> 1. SLTU with the same operands -> 0.
REQ-032 DIV with A=0xFFFFFFF9 (-7), B=2 -> 0xFFFFFFFD, latency 33. REM with the same operands -> 0xFFFFFFFF. MULHU with A=B=0xFFFFFFFF -> 0xFFFFFFFE; MUL with the same operands -> 0x00000001.
REQ-033 DIVU with A=5, B=0 -> 0xFFFFFFFF, latency 1. REMU with A=5, B=0 -> 5. DIV with A=0x80000000, B=0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
REQ-034 Hold iReady low for 3 cycles in DONE -> oC and oValid remain constant and oReady stays low. Pulse nRst low for a partial cycle mid-CALC -> oValid=0, oReady=1 immediately, with no late result.
REQ-035 With WIDTH=8, DIVU with A=0xFF, B=0x10 -> 0x0F, latency 9; SLL with B=0x0B -> shift by 3.
